// File: rtl/regfile_writeback_if.sv
// Bundle between execute/LSU stages, issue logic and the register-file write port
// for the writeback arbiter.
interface regfile_writeback_if #(
    parameter int XLEN           = 32,
    parameter int LSU_FIFO_DEPTH = 2
);
    logic                              alu_valid;
    logic                              alu_ready;
    logic [4:0]                        alu_rd;
    logic [XLEN-1:0]                   alu_data;
    logic                              lsu_valid;
    logic                              lsu_ready;
    logic [4:0]                        lsu_rd;
    logic [XLEN-1:0]                   lsu_data;
    logic                              sb_set_valid;
    logic [4:0]                        sb_set_rd;
    logic [31:0]                       sb_busy;
    logic                              wb_we;
    logic [4:0]                        wb_addr;
    logic [XLEN-1:0]                   wb_data;
    logic [$clog2(LSU_FIFO_DEPTH):0]   fifo_count;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        output sb_set_valid, sb_set_rd,
        input  alu_ready, lsu_ready, sb_busy,
        input  wb_we, wb_addr, wb_data, fifo_count
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        input  sb_set_valid, sb_set_rd,
        output alu_ready, lsu_ready, sb_busy,
        output wb_we, wb_addr, wb_data, fifo_count
    );
endinterface

// File: rtl/regfile_writeback.sv
// Register-file writeback arbiter: ALU results win by default, LSU results are
// buffered in a small FIFO with a starvation guard, plus a pending-write scoreboard.
module regfile_writeback #(
    parameter int XLEN           = 32,
    parameter int LSU_FIFO_DEPTH = 2,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic               clk,
    input  logic               rstf,
    regfile_writeback_if.slave bus
);
    localparam int PTR_W = $clog2(LSU_FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(LSU_FIFO_DEPTH);
    localparam logic [SC_W-1:0]  LIMIT_C = SC_W'(STARVE_LIMIT);

    logic [4:0]      mem_rd   [LSU_FIFO_DEPTH];
    logic [XLEN-1:0] mem_data [LSU_FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [SC_W-1:0]  starve_q, starve_d;
    logic [31:0]      busy_q, busy_d;
    logic             we_q, we_d;
    logic [4:0]       addr_q, addr_d;
    logic [XLEN-1:0]  data_q, data_d;

    logic fifo_nonempty;
    logic alu_ready;
    logic lsu_ready;
    logic alu_write;
    logic push;
    logic pop;

    assign fifo_nonempty = (count_q != '0);
    assign lsu_ready     = (count_q < DEPTH_C);
    assign alu_ready     = !(fifo_nonempty && (starve_q == LIMIT_C));

    // An rd=0 transfer on either side is consumed without producing a write.
    assign alu_write = bus.alu_valid && alu_ready && (bus.alu_rd != 5'd0);
    assign push      = bus.lsu_valid && lsu_ready && (bus.lsu_rd != 5'd0);
    assign pop       = fifo_nonempty && !alu_write;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        starve_d = starve_q;
        busy_d   = busy_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;

        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (pop || !fifo_nonempty) begin
            starve_d = '0;
        end else if (alu_write && (starve_q != LIMIT_C)) begin
            starve_d = starve_q + SC_W'(1);
        end

        if (alu_write) begin
            we_d   = 1'b1;
            addr_d = bus.alu_rd;
            data_d = bus.alu_data;
        end else if (pop) begin
            we_d   = 1'b1;
            addr_d = mem_rd[rd_ptr_q];
            data_d = mem_data[rd_ptr_q];
        end

        // Clear before set so an issue to the same rd in the same cycle stays pending.
        if (pop) busy_d[mem_rd[rd_ptr_q]] = 1'b0;
        if (bus.sb_set_valid && (bus.sb_set_rd != 5'd0)) busy_d[bus.sb_set_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstf) begin
        if (!rstf) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            busy_q   <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            busy_q   <= busy_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
        end
    end

    // NOTE: FIFO storage is not reset; occupancy and pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_rd[wr_ptr_q]   <= bus.lsu_rd;
            mem_data[wr_ptr_q] <= bus.lsu_data;
        end
    end

    assign bus.alu_ready  = alu_ready;
    assign bus.lsu_ready  = lsu_ready;
    assign bus.sb_busy    = busy_q;
    assign bus.wb_we      = we_q;
    assign bus.wb_addr    = addr_q;
    assign bus.wb_data    = data_q;
    assign bus.fifo_count = count_q;
endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: ALU path, LSU path with scoreboard,
// FIFO full, starvation guard, x0 handling and mid-stream reset.
module tb_regfile_writeback;
    localparam int XLEN = 32;

    logic clk;
    logic rstf;
    int   n_tests = 0;
    int   n_fail  = 0;

    regfile_writeback_if #(.XLEN(XLEN), .LSU_FIFO_DEPTH(2)) bus ();

    regfile_writeback #(
        .XLEN(XLEN), .LSU_FIFO_DEPTH(2), .STARVE_LIMIT(4)
    ) dut (
        .clk  (clk),
        .rstf (rstf),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.alu_valid    = 1'b0;
        bus.alu_rd       = 5'd0;
        bus.alu_data     = '0;
        bus.lsu_valid    = 1'b0;
        bus.lsu_rd       = 5'd0;
        bus.lsu_data     = '0;
        bus.sb_set_valid = 1'b0;
        bus.sb_set_rd    = 5'd0;
    endtask

    task automatic check_wb(input string tag, input logic we, input logic [4:0] addr,
                            input logic [XLEN-1:0] data);
        check({tag, ".we"}, bus.wb_we, we);
        check({tag, ".addr"}, bus.wb_addr, addr);
        check({tag, ".data"}, bus.wb_data, data);
    endtask

    task automatic check_reset_state(input string tag);
        check_wb(tag, 1'b0, 5'd0, '0);
        check({tag, ".busy"}, bus.sb_busy, 32'h0);
        check({tag, ".count"}, bus.fifo_count, 2'd0);
        check({tag, ".lsu_ready"}, bus.lsu_ready, 1'b1);
        check({tag, ".alu_ready"}, bus.alu_ready, 1'b1);
    endtask

    initial begin
        idle();
        rstf = 1'b0;
        #1;
        check_reset_state("reset");
        #11;
        rstf = 1'b1;
        tick();
        check("post_reset.we", bus.wb_we, 1'b0);

        // ALU only
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF;
        #1 check("alu.ready", bus.alu_ready, 1'b1);
        tick();
        idle();
        check_wb("alu.wb", 1'b1, 5'd5, 32'hDEADBEEF);
        check("alu.ready_after", bus.alu_ready, 1'b1);
        tick();
        check_wb("alu.hold", 1'b0, 5'd5, 32'hDEADBEEF);

        // LSU with scoreboard
        bus.sb_set_valid = 1'b1; bus.sb_set_rd = 5'd7;
        tick();
        idle();
        check("sb.set7", bus.sb_busy, 32'h0000_0080);
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd7; bus.lsu_data = 32'h1234;
        #1 check("lsu.ready", bus.lsu_ready, 1'b1);
        tick();
        idle();
        check("lsu.count1", bus.fifo_count, 2'd1);
        check("lsu.no_we_yet", bus.wb_we, 1'b0);
        check("lsu.busy_still", bus.sb_busy, 32'h0000_0080);
        tick();
        check_wb("lsu.wb", 1'b1, 5'd7, 32'h1234);
        check("lsu.busy_clear", bus.sb_busy, 32'h0);
        check("lsu.count0", bus.fifo_count, 2'd0);

        // FIFO full with ALU held valid
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_data = 32'hA0;
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd10; bus.lsu_data = 32'h100;
        tick();
        check("full.e1.count", bus.fifo_count, 2'd1);
        check_wb("full.e1", 1'b1, 5'd1, 32'hA0);
        bus.lsu_rd = 5'd11; bus.lsu_data = 32'h101;
        tick();
        check("full.e2.count", bus.fifo_count, 2'd2);
        check("full.e2.lsu_ready", bus.lsu_ready, 1'b0);
        check("full.e2.alu_ready", bus.alu_ready, 1'b1);
        bus.lsu_rd = 5'd12; bus.lsu_data = 32'h102;
        tick();
        tick();
        check("full.e4.count", bus.fifo_count, 2'd2);
        check("full.e4.alu_ready", bus.alu_ready, 1'b1);
        tick();
        check("full.e5.alu_ready", bus.alu_ready, 1'b0);
        check_wb("full.e5", 1'b1, 5'd1, 32'hA0);
        tick();
        check_wb("full.e6.pop", 1'b1, 5'd10, 32'h100);
        check("full.e6.count", bus.fifo_count, 2'd1);
        check("full.e6.lsu_ready", bus.lsu_ready, 1'b1);
        check("full.e6.alu_ready", bus.alu_ready, 1'b1);
        tick();
        idle();
        check_wb("full.e7.alu", 1'b1, 5'd1, 32'hA0);
        check("full.e7.count", bus.fifo_count, 2'd2);
        tick();
        check_wb("full.e8.pop", 1'b1, 5'd11, 32'h101);
        tick();
        check_wb("full.e9.pop", 1'b1, 5'd12, 32'h102);
        check("full.e9.count", bus.fifo_count, 2'd0);
        tick();
        check("full.e10.we", bus.wb_we, 1'b0);

        // Starvation: one FIFO entry, ALU valid every cycle
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd2; bus.alu_data = 32'h2222;
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd20; bus.lsu_data = 32'h2020;
        tick();
        bus.lsu_valid = 1'b0;
        check("starve.f1.count", bus.fifo_count, 2'd1);
        check_wb("starve.f1", 1'b1, 5'd2, 32'h2222);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check_wb($sformatf("starve.win%0d", i), 1'b1, 5'd2, 32'h2222);
            check($sformatf("starve.ready%0d", i), bus.alu_ready, (i == 4) ? 1'b0 : 1'b1);
        end
        tick();
        check_wb("starve.pop", 1'b1, 5'd20, 32'h2020);
        check("starve.ready_back", bus.alu_ready, 1'b1);
        tick();
        idle();
        check_wb("starve.resume", 1'b1, 5'd2, 32'h2222);
        tick();
        check("starve.idle.we", bus.wb_we, 1'b0);

        // x0 handling, plus same-edge set/clear of one rd
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd3; bus.lsu_data = 32'h33;
        bus.sb_set_valid = 1'b1; bus.sb_set_rd = 5'd3;
        tick();
        idle();
        check("x0.count1", bus.fifo_count, 2'd1);
        check("x0.busy3", bus.sb_busy, 32'h0000_0008);
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'hFF;
        bus.sb_set_valid = 1'b1; bus.sb_set_rd = 5'd3;
        #1 check("x0.alu_ready", bus.alu_ready, 1'b1);
        tick();
        idle();
        check_wb("x0.fifo_write", 1'b1, 5'd3, 32'h33);
        check("x0.set_wins", bus.sb_busy, 32'h0000_0008);
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd0; bus.lsu_data = 32'h55;
        bus.sb_set_valid = 1'b1; bus.sb_set_rd = 5'd0;
        #1 check("x0.lsu_ready", bus.lsu_ready, 1'b1);
        tick();
        idle();
        check("x0.lsu_drop", bus.fifo_count, 2'd0);
        check("x0.no_we", bus.wb_we, 1'b0);
        check("x0.sb_unchanged", bus.sb_busy, 32'h0000_0008);
        tick();
        check("x0.still_no_we", bus.wb_we, 1'b0);

        // Reset mid-stream
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd4; bus.alu_data = 32'h4444;
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd9; bus.lsu_data = 32'h99;
        bus.sb_set_valid = 1'b1; bus.sb_set_rd = 5'd9;
        tick();
        bus.sb_set_valid = 1'b0;
        bus.lsu_rd = 5'd13; bus.lsu_data = 32'hD;
        tick();
        idle();
        check("rst.pre.count", bus.fifo_count, 2'd2);
        check("rst.pre.busy", bus.sb_busy, 32'h0000_0208);
        rstf = 1'b0;
        #1;
        check_reset_state("rst.mid");
        @(negedge clk);
        rstf = 1'b1;
        tick();
        check("rst.after1.we", bus.wb_we, 1'b0);
        check("rst.after1.count", bus.fifo_count, 2'd0);
        tick();
        check("rst.after2.we", bus.wb_we, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
